ripple_ca_adder: RTL and testbench

- WIDTH-bit unsigned ripple-carry adder. Carry propagates through a chain of 1-bit full-adder cells.
- Sum and carry-out are captured in output registers, so latency is fixed at one clock cycle.
- Leaf arithmetic block, used standalone or as the datapath adder inside larger arithmetic units.
- No handshake. New operands are accepted every cycle.

---
 rtl/adder_pkg.sv | 10 +
 rtl/full_adder.sv | 21 ++
 rtl/ripple_ca_adder.sv | 65 ++++++
 tb/tb_ripple_ca_adder.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the ripple-carry adder and anything that models it.
//   DEFAULT_ADDER_WIDTH : default operand width of ripple_ca_adder
//   adder_result_t      : {carry, sum} result at the default width
package adder_pkg;

  localparam int DEFAULT_ADDER_WIDTH = 4;

  typedef logic [DEFAULT_ADDER_WIDTH:0] adder_result_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, purely combinational.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   cout  : carry out (generate, or propagate of cin)
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic prop;

  assign prop = a ^ b;
  assign sum  = prop ^ cin;
  assign cout = (a & b) | (cin & prop);

endmodule

// File: rtl/ripple_ca_adder.sv
// WIDTH-bit unsigned ripple-carry adder with registered outputs (one cycle latency).
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears sum/carry immediately
//   a, b  : unsigned operands
//   sum   : registered low WIDTH bits of a+b
//   carry : registered carry-out of a+b
module ripple_ca_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             carry_d, carry_q;

  // Each stage owns its carry-in/carry-out nets; chaining through the previous
  // generate block keeps every carry a distinct signal rather than bits of one
  // vector that feeds itself.
  for (genvar i = 0; i < WIDTH; i++) begin : gen_fa
    logic cin;
    logic cout;

    if (i == 0) begin : gen_lsb
      assign cin = 1'b0;
    end else begin : gen_chain
      assign cin = gen_fa[i-1].cout;
    end

    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (cin),
      .sum (s[i]),
      .cout(cout)
    );
  end

  always_comb begin
    sum_d   = s;
    carry_d = gen_fa[WIDTH-1].cout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_ripple_ca_adder.sv
module tb_ripple_ca_adder;
  import adder_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       carry4;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic       carry1;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       carry8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ripple_ca_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .a(a4), .b(b4), .sum(sum4), .carry(carry4));
  ripple_ca_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .sum(sum1), .carry(carry1));
  ripple_ca_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .a(a8), .b(b8), .sum(sum8), .carry(carry8));

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_sum;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got {carry,sum}=0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    adder_result_t exp4;
    logic [8:0]    exp8;
    logic [1:0]    exp1;
    logic [3:0]    pa, pb;

    vecs[0] = '{4'd0, 4'd8,  4'd8,  1'b0};
    vecs[1] = '{4'd1, 4'd14, 4'd15, 1'b0};
    vecs[2] = '{4'd2, 4'd12, 4'd14, 1'b0};
    vecs[3] = '{4'd4, 4'd11, 4'd15, 1'b0};
    vecs[4] = '{4'd5, 4'd6,  4'd11, 1'b0};
    vecs[5] = '{4'd6, 4'd1,  4'd7,  1'b0};
    vecs[6] = '{4'd7, 4'd9,  4'd0,  1'b1};
    vecs[7] = '{4'd8, 4'd8,  4'd0,  1'b1};
    vecs[8] = '{4'd15, 4'd15, 4'd14, 1'b1};
    vecs[9] = '{4'd0, 4'd0,  4'd0,  1'b0};

    // Reset held through a clock edge: outputs stay zero.
    a4 = 4'd9; b4 = 4'd9;
    tick();
    check("reset_hold", {4'b0, carry4, sum4}, 9'd0);

    // Release, make outputs non-zero.
    rst = 1'b0;
    a4 = 4'd5; b4 = 4'd6;
    tick();
    check("pre_reset_value", {4'b0, carry4, sum4}, 9'd11);

    // Mid-cycle async reset: must clear before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("async_reset_clear", {4'b0, carry4, sum4}, 9'd0);
    tick();
    check("async_reset_held", {4'b0, carry4, sum4}, 9'd0);

    // Release mid-cycle with 3+8 applied; first edge after release captures it.
    #2 rst = 1'b0;
    a4 = 4'd3; b4 = 4'd8;
    tick();
    check("post_reset_3p8", {4'b0, carry4, sum4}, 9'd11);

    // Directed table: sweep, wrap, max, zero.
    for (int i = 0; i < 10; i++) begin
      a4 = vecs[i].a; b4 = vecs[i].b;
      tick();
      check($sformatf("vec%0d_%0d+%0d", i, vecs[i].a, vecs[i].b),
            {4'b0, carry4, sum4}, {4'b0, vecs[i].exp_carry, vecs[i].exp_sum});
    end

    // Back-to-back: operands change every cycle, output tracks previous cycle's operands.
    a4 = 4'd0; b4 = 4'd3;
    tick();
    for (int i = 1; i <= 16; i++) begin
      pa = a4; pb = b4;
      a4 = 4'(i); b4 = 4'((i * 7 + 3) % 16);
      #1;
      check($sformatf("b2b_hold%0d", i), {4'b0, carry4, sum4},
            {4'b0, adder_result_t'({1'b0, pa}) + adder_result_t'({1'b0, pb})});
      @(posedge clk);
      #1;
      exp4 = adder_result_t'({1'b0, a4}) + adder_result_t'({1'b0, b4});
      check($sformatf("b2b%0d", i), {4'b0, carry4, sum4}, {4'b0, exp4});
    end

    // Exhaustive WIDTH=4.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a4 = 4'(i); b4 = 4'(j);
        exp4 = adder_result_t'(i + j);
        tick();
        check($sformatf("w4_%0d+%0d", i, j), {4'b0, carry4, sum4}, {4'b0, exp4});
      end
    end

    // Exhaustive WIDTH=1.
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        a1 = 1'(i); b1 = 1'(j);
        exp1 = 2'(i + j);
        tick();
        check($sformatf("w1_%0d+%0d", i, j), {7'b0, carry1, sum1}, {7'b0, exp1});
      end
    end

    // Exhaustive WIDTH=8.
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        a8 = 8'(i); b8 = 8'(j);
        exp8 = 9'(i + j);
        tick();
        check($sformatf("w8_%0d+%0d", i, j), {carry8, sum8}, exp8);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
